// File: rtl/axi_mm_traffic_gen.sv
// Single-clock AXI4 burst traffic generator and read-back checker.
// Writes seeded INCR bursts, reads the region back, counts mismatches.
module axi_mm_traffic_gen #(
  parameter int          ADDRWIDTH = 32,
  parameter int          DWIDTH    = 64,
  parameter int          IDWIDTH   = 4,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic                 start,
  input  logic [7:0]           num_bursts,
  input  logic [7:0]           burst_len,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic                 timeout,
  output logic [IDWIDTH-1:0]   awid,
  output logic [ADDRWIDTH-1:0] awaddr,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [IDWIDTH-1:0]   wid,
  output logic [DWIDTH-1:0]    wdata,
  output logic [DWIDTH/8-1:0]  wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [IDWIDTH-1:0]   bid,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [IDWIDTH-1:0]   arid,
  output logic [ADDRWIDTH-1:0] araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [IDWIDTH-1:0]   rid,
  input  logic [DWIDTH-1:0]    rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready
);

  typedef enum logic [2:0] {
    IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             nb_q, nb_d, len_q, len_d;
  logic [7:0]             burst_q, burst_d, beat_q, beat_d;
  logic [ADDRWIDTH-1:0]   base_q, base_d, addr_q, addr_d, step;
  logic [31:0]            seed_q, seed_d;
  logic [15:0]            idx_q, idx_d, err_q, err_d, wdog_q, wdog_d;
  logic                   to_q, to_d, busy_q, busy_d;
  logic                   done_q, done_d, pass_q, pass_d;
  logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                   wlast_q, wlast_d, bready_q, bready_d;
  logic                   arvalid_q, arvalid_d, rready_q, rready_d;
  logic [DWIDTH-1:0]      wdata_q, wdata_d;
  logic                   hs, waiting, is_last;
  logic [2:0]             nerr;
  logic [16:0]            esum;

  function automatic logic [DWIDTH-1:0] pat(
    input logic [31:0] s,
    input logic [15:0] i
  );
    logic [31:0] lo;
    lo = s + {16'd0, i};
    return DWIDTH'({~lo, lo});
  endfunction

  assign step    = ADDRWIDTH'((32'(len_q) + 32'd1) << 3);
  assign is_last = (beat_q == len_q);

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    len_d   = len_q;
    base_d  = base_q;
    seed_d  = seed_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    err_d   = err_q;
    to_d    = to_q;
    hs      = 1'b0;
    waiting = 1'b0;
    nerr    = '0;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        nb_d    = num_bursts;
        len_d   = burst_len;
        base_d  = base_addr;
        seed_d  = seed;
        addr_d  = base_addr;
        burst_d = '0;
        beat_d  = '0;
        idx_d   = '0;
        err_d   = '0;
        to_d    = 1'b0;
        state_d = (num_bursts == 8'd0) ? DONE : WR_AW;
      end
      WR_AW: begin
        waiting = 1'b1;
        if (awready) begin
          hs      = 1'b1;
          state_d = WR_W;
        end
      end
      WR_W: begin
        waiting = 1'b1;
        if (wready) begin
          hs     = 1'b1;
          idx_d  = idx_q + 16'd1;
          beat_d = beat_q + 8'd1;
          if (is_last) begin
            beat_d  = '0;
            state_d = WR_B;
          end
        end
      end
      WR_B: begin
        waiting = 1'b1;
        if (bvalid) begin
          hs   = 1'b1;
          nerr = {2'b0, (bresp != 2'b00) || (bid != '0)};
          if (burst_q == nb_q - 8'd1) begin
            burst_d = '0;
            addr_d  = base_q;
            idx_d   = '0;
            state_d = RD_AR;
          end else begin
            burst_d = burst_q + 8'd1;
            addr_d  = addr_q + step;
            state_d = WR_AW;
          end
        end
      end
      RD_AR: begin
        waiting = 1'b1;
        if (arready) begin
          hs      = 1'b1;
          state_d = RD_R;
        end
      end
      RD_R: begin
        waiting = 1'b1;
        if (rvalid) begin
          hs     = 1'b1;
          nerr   = {2'b0, rdata != pat(seed_q, idx_q)}
                 + {2'b0, rresp != 2'b00}
                 + {2'b0, rid != '0}
                 + {2'b0, rlast && !is_last};
          idx_d  = idx_q + 16'd1;
          beat_d = beat_q + 8'd1;
          if (is_last) begin
            beat_d = '0;
            if (burst_q == nb_q - 8'd1) begin
              state_d = DONE;
            end else begin
              burst_d = burst_q + 8'd1;
              addr_d  = addr_q + step;
              state_d = RD_AR;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    esum = {1'b0, err_q} + {14'd0, nerr};
    if (nerr != 3'd0) err_d = esum[16] ? 16'hFFFF : esum[15:0];

    // Watchdog: any single stalled handshake aborts the whole test
    if (waiting && !hs && (wdog_q >= TIMEOUT - 16'd1)) begin
      to_d    = 1'b1;
      state_d = DONE;
    end
    if (hs || state_d != state_q || !waiting) wdog_d = '0;
    else                                     wdog_d = wdog_q + 16'd1;

    busy_d    = !(state_d inside {IDLE, DONE});
    done_d    = (state_d == DONE);
    pass_d    = done_d && (err_d == 16'd0) && !to_d;
    awvalid_d = (state_d == WR_AW);
    wvalid_d  = (state_d == WR_W);
    bready_d  = (state_d == WR_B);
    arvalid_d = (state_d == RD_AR);
    rready_d  = (state_d == RD_R);
    wdata_d   = pat(seed_d, idx_d);
    wlast_d   = (beat_d == len_d);
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q   <= IDLE;
      nb_q      <= '0;
      len_q     <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      to_q      <= 1'b0;
      wdog_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      nb_q      <= nb_d;
      len_q     <= len_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      to_q      <= to_d;
      wdog_q    <= wdog_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign timeout   = to_q;
  assign awid      = '0;
  assign awaddr    = addr_q;
  assign awlen     = len_q;
  assign awsize    = 3'd3;
  assign awburst   = 2'b01;
  assign awvalid   = awvalid_q;
  assign wid       = '0;
  assign wdata     = wdata_q;
  assign wstrb     = '1;
  assign wlast     = wlast_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arid      = '0;
  assign araddr    = addr_q;
  assign arlen     = len_q;
  assign arsize    = 3'd3;
  assign arburst   = 2'b01;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi_mm_traffic_gen.sv
// Bench for axi_mm_traffic_gen: loopback memory slave with optional
// backpressure and fault injection, table of runs plus corner sequences.
module tb_axi_mm_traffic_gen;

  logic        clk, rst_n, start;
  logic [7:0]  num_bursts, burst_len;
  logic [31:0] base_addr, seed;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [3:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  axi_mm_traffic_gen #(
    .ADDRWIDTH(32), .DWIDTH(64), .IDWIDTH(4), .TIMEOUT(16'd100)
  ) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .start(start),
    .num_bursts(num_bursts), .burst_len(burst_len),
    .base_addr(base_addr), .seed(seed),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout(timeout),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory slave model
  logic [63:0] mem [0:1023];
  logic        bp, corrupt, berr, aw_off, mclr;
  int          pend_b, b_cnt, ar_cnt, rbeat, rlen, n_aw;
  int          stall_viol, field_bad;
  logic        r_active, r_took, pv_aw, pv_w, pv_ar, first_seen;
  logic [31:0] waddr, raddr, p_awaddr, p_araddr;
  logic [64:0] p_w;
  logic [63:0] first_w;
  logic [31:0] aw_log [$];

  assign bid = '0;
  assign rid = '0;
  assign rresp = 2'b00;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || mclr) begin
      pend_b = 0; b_cnt = 0; ar_cnt = 0; rbeat = 0; rlen = 0;
      n_aw = 0; stall_viol = 0; field_bad = 0;
      r_active = 0; r_took = 0; first_seen = 0;
      pv_aw = 0; pv_w = 0; pv_ar = 0;
      aw_log.delete();
    end else begin
      r_took = 0;
      if (pv_aw && (!awvalid || awaddr != p_awaddr)) stall_viol++;
      if (pv_w && (!wvalid || {wlast, wdata} != p_w)) stall_viol++;
      if (pv_ar && (!arvalid || araddr != p_araddr)) stall_viol++;
      pv_aw = awvalid && !awready; p_awaddr = awaddr;
      pv_w  = wvalid && !wready;   p_w = {wlast, wdata};
      pv_ar = arvalid && !arready; p_araddr = araddr;
      if (awvalid && awready) begin
        if (awsize != 3 || awburst != 1 || awid != 0) field_bad++;
        waddr = awaddr; n_aw++; aw_log.push_back(awaddr);
      end
      if (wvalid && wready) begin
        if (wstrb != 8'hFF || wid != 0) field_bad++;
        if (!first_seen) begin first_w = wdata; first_seen = 1; end
        mem[waddr[12:3]] = wdata; waddr += 8;
        if (wlast) pend_b++;
      end
      if (bvalid && bready) begin pend_b--; b_cnt++; end
      if (arvalid && arready) begin
        if (arsize != 3 || arburst != 1 || arid != 0) field_bad++;
        raddr = araddr; rlen = int'(arlen); rbeat = 0;
        r_active = 1; ar_cnt++;
      end
      if (rvalid && rready) begin
        r_took = 1; rbeat++; raddr += 8;
        if (rbeat > rlen) r_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0;
      bresp = 0; rvalid = 0; rdata = 0; rlast = 0;
    end else begin
      awready = aw_off ? 1'b0 : (bp ? rb() : 1'b1);
      wready  = bp ? rb() : 1'b1;
      arready = bp ? rb() : 1'b1;
      bvalid  = (pend_b > 0);
      bresp   = (berr && b_cnt == 0) ? 2'b10 : 2'b00;
      if (!(rvalid && !r_took)) begin
        rvalid = r_active && (bp ? rb() : 1'b1);
        rdata  = mem[raddr[12:3]]
               ^ ((corrupt && ar_cnt == 3 && rbeat == 3) ? 64'h10 : 64'h0);
        rlast  = r_active && (rbeat == rlen);
      end
    end
  end

  typedef struct {
    logic [7:0]  nb;
    logic [7:0]  len;
    logic [31:0] base;
    logic [31:0] sd;
    logic        bp;
    logic        corrupt;
    logic        berr;
    logic        exp_pass;
    logic [15:0] exp_err;
    int          exp_aw;
    int          exp_cyc;
  } vec_t;

  vec_t vt [5];
  int   cyc;

  task automatic kick(input logic [7:0] nb, input logic [7:0] len,
                      input logic [31:0] base, input logic [31:0] sd);
    @(negedge clk);
    num_bursts = nb; burst_len = len; base_addr = base; seed = sd;
    mclr = 1; start = 1;
    @(negedge clk);
    mclr = 0; start = 0;
  endtask

  task automatic wait_done(output int c_busy);
    c_busy = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      if (busy) c_busy++;
      @(negedge clk);
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    vt[0] = '{8'd4, 8'd7, 32'h1000, 32'hA5A50000,
              1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 4, 76};
    vt[1] = '{8'd4, 8'd7, 32'h1000, 32'hA5A50000,
              1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 4, -1};
    vt[2] = '{8'd4, 8'd7, 32'h1000, 32'hA5A50000,
              1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 4, 76};
    vt[3] = '{8'd3, 8'd0, 32'h2000, 32'hFFFFFFFE,
              1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 3, -1};
    vt[4] = '{8'd2, 8'd15, 32'h0, 32'h12345678,
              1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 2, 70};

    rst_n = 0; start = 0; num_bursts = 0; burst_len = 0;
    base_addr = 0; seed = 0; bp = 0; corrupt = 0; berr = 0;
    aw_off = 0; mclr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_state",
        {awvalid, wvalid, bready, arvalid, rready,
         busy, done, pass, timeout, err_count}, 0);

    for (int i = 0; i < 5; i++) begin
      bp = vt[i].bp; corrupt = vt[i].corrupt; berr = vt[i].berr;
      kick(vt[i].nb, vt[i].len, vt[i].base, vt[i].sd);
      chk($sformatf("v%0d_busy_n1", i), {busy, awvalid}, 2'b11);
      wait_done(cyc);
      chk($sformatf("v%0d_pass", i), pass, vt[i].exp_pass);
      chk($sformatf("v%0d_err", i), err_count, vt[i].exp_err);
      chk($sformatf("v%0d_timeout", i), timeout, 0);
      chk($sformatf("v%0d_busy_low", i), busy, 0);
      chk($sformatf("v%0d_naw", i), n_aw, vt[i].exp_aw);
      chk($sformatf("v%0d_stable", i), stall_viol, 0);
      chk($sformatf("v%0d_fields", i), field_bad, 0);
      if (vt[i].exp_cyc >= 0)
        chk($sformatf("v%0d_cycles", i), cyc, vt[i].exp_cyc);
      if (i == 0) begin
        chk("v0_aw0", aw_log[0], 32'h1000);
        chk("v0_aw1", aw_log[1], 32'h1040);
        chk("v0_aw2", aw_log[2], 32'h1080);
        chk("v0_aw3", aw_log[3], 32'h10C0);
        chk("v0_first_wdata", first_w, 64'h5A5AFFFF_A5A50000);
      end
    end
    bp = 0; corrupt = 0; berr = 0;

    // Zero bursts: done/pass one cycle after start, no traffic
    kick(8'd0, 8'd7, 32'h1000, 32'h1);
    chk("nb0_done_pass_busy", {done, pass, busy}, 3'b110);
    repeat (3) @(negedge clk);
    chk("nb0_no_aw", n_aw + int'(awvalid), 0);

    // Start pulsed while busy is ignored
    kick(8'd2, 8'd3, 32'h3000, 32'h77);
    repeat (4) @(negedge clk);
    base_addr = 32'h5000; num_bursts = 8'd9; start = 1;
    @(negedge clk);
    start = 0;
    chk("ign_busy", busy, 1);
    wait_done(cyc);
    chk("ign_naw", n_aw, 2);
    chk("ign_aw1", aw_log[1], 32'h3020);
    chk("ign_pass", pass, 1);

    // Asynchronous reset while reading
    kick(8'd2, 8'd7, 32'h1000, 32'hCAFE0000);
    for (int c = 0; c < 500 && !rready; c++) @(negedge clk);
    chk("reach_rd_r", rready, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_outs",
        {awvalid, wvalid, bready, arvalid, rready,
         busy, done, pass, timeout, err_count}, 0);
    @(negedge clk);
    rst_n = 1;
    kick(8'd2, 8'd7, 32'h1000, 32'hCAFE0000);
    wait_done(cyc);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_err", err_count, 0);

    // Watchdog on a stuck awready
    aw_off = 1;
    kick(8'd1, 8'd3, 32'h1000, 32'h5);
    cyc = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      if (awvalid) cyc++;
      @(negedge clk);
    end
    chk("to_done", done, 1);
    chk("to_flag", timeout, 1);
    chk("to_awvalid", awvalid, 0);
    chk("to_pass", pass, 0);
    chk("to_stall_cycles", cyc, 100);
    aw_off = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mm_traffic_gen.md
# axi_mm_traffic_gen

Single-clock AXI4 burst traffic generator and checker that drives the `user_axi_if` slave port of the AIB-to-AXI bridge master, directly upstream of it. It writes a programmable number of INCR bursts with a seed-derived data pattern, then reads the same region back and compares it. Pass/fail, an error count and a timeout flag are reported for bring-up and link qualification.

## Interface
Parameters:
- `ADDRWIDTH`, 32: AXI address width.
- `DWIDTH`, 64: AXI data width; `wstrb` is DWIDTH/8 bits.
- `IDWIDTH`, 4: AXI ID width.
- `TIMEOUT`, 16'hFFFF: maximum cycles spent waiting on any single handshake.

Ports:
- `clk_wr`  in  1  sole clock.
- `rst_wr_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; ignored while `busy`.
- `num_bursts`  in  8  bursts per pass; sampled on `start`.
- `burst_len`  in  8  AXI len (beats−1); sampled on `start`.
- `base_addr`  in  ADDRWIDTH  first burst address, 8-byte aligned; sampled on `start`.
- `seed`  in  32  data-pattern seed; sampled on `start`.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until next accepted `start`.
- `pass`  out  1  `done` && `err_count`==0 && !`timeout`.
- `err_count`  out  16  saturating error count.
- `timeout`  out  1  handshake watchdog expired.
- AXI master, user side: `aw{id,addr,len,size,burst,valid}`/`awready`, `w{id,data,strb,last,valid}`/`wready`, `b{id,resp,valid}`/`bready`, `ar{id,addr,len,size,burst,valid}`/`arready`, `r{id,data,resp,last,valid}`/`rready`, with standard AXI4 widths.

## Operation
- Fixed fields: `*size`=3'd3, `*burst`=2'b01 (INCR), all IDs=0, `wstrb`=all ones.
- Burst k address = `base_addr` + k·(`burst_len`+1)·8, computed modulo 2^ADDRWIDTH.
- Beat data: idx = 16-bit running beat counter, reset to 0 at the start of each phase. Data = {~(seed+idx), seed+idx} in 32-bit arithmetic, with wraparound.
- FSM: IDLE → WR_AW → WR_W → WR_B → (next burst: WR_AW | last burst: RD_AR) → RD_R → (next burst: RD_AR | last burst: DONE).
  - IDLE/DONE + `start`: latch the inputs, clear `err_count`/`timeout`, and go to WR_AW. If `num_bursts`==0, go straight to DONE with `pass`=1.
  - WR_AW: hold `awvalid` until `awready`.
  - WR_W: stream `burst_len`+1 beats. `wlast` is asserted on the final beat only. W starts only after the AW handshake.
  - WR_B: `bready`=1. On `bvalid`, count an error if `bresp`≠0 or `bid`≠0.
  - RD_AR: hold `arvalid` until `arready`.
  - RD_R: `rready`=1. For each beat, count 1 error per condition: `rdata`≠expected, `rresp`≠0, `rid`≠0, or `rlast` asserted on the wrong beat. A burst ends on the expected final beat regardless of `rlast`.
- `err_count` saturates at 16'hFFFF.
- Watchdog: a 16-bit counter resets on every handshake and on every state change, and increments while waiting in WR_AW, WR_W, WR_B, RD_AR or RD_R. On reaching `TIMEOUT`, set `timeout`, drop all valids/readies, and go to DONE.
- `start` in DONE restarts the test. `start` while busy has no effect.

## Timing
- Reset values: all `*valid`/`*ready`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `timeout`=0, FSM in IDLE. Reset mid-operation aborts the test immediately and asynchronously.
- `start` accepted in cycle N: `busy`=1 and `awvalid`=1 in cycle N+1.
- All outputs are registered; there is no combinational path from any `*ready` to any `*valid`.
- A valid, once asserted, is held with stable payload until its handshake completes.
- `wvalid` is continuous across a burst: one beat per cycle while `wready`=1.
- Minimum burst cost: 1 (AW) + `burst_len`+1 (W) + 1 (B) cycles with zero backpressure. Reads cost 1 (AR) + `burst_len`+1 (R) cycles.
- `done`/`pass` rise the cycle after the final R beat. `busy` falls in the same cycle.

## Test plan
- Loopback memory model with zero wait states; `num_bursts`=4, `burst_len`=7, `base_addr`=0x1000, `seed`=0xA5A50000 → 4 AW at 0x1000/0x1040/0x1080/0x10C0. The first `wdata` is 0x5A5AFFFF_A5A50000. Result: `pass`=1, `err_count`=0.
- Random `awready`/`wready`/`arready`/`rvalid` backpressure at 50% → payloads stay stable while stalled; `pass`=1.
- Memory model corrupts one bit of beat 3 in burst 2 and returns `bresp`=2'b10 once → `err_count`=2, `pass`=0.
- `awready` tied 0 with `TIMEOUT`=100 → `timeout`=1 after 100 stalled cycles, `done`=1, `awvalid`=0.
- `num_bursts`=0 → `done`=1 and `pass`=1 one cycle after `start`, with no AXI traffic. `start` pulsed while busy → ignored.
- Assert `rst_wr_n` mid-RD_R → all outputs return to their reset values immediately. A new `start` then completes with `pass`=1.
